rob_multiport: RTL and testbench

Parametrised reorder buffer for the superscalar core. It supports configurable depth, multiple CDB writeback ports, a commit valid/ready handshake and mispredict flush. Issue allocates entries in program order, decode reads operand status by ROB index, CDB ports mark entries done, and the head entry retires in order. It sits between issue/decode and the register-file commit stage.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/rob_cdb_match.sv | 29 ++
 rtl/rob_multiport.sv | 189 ++++++++++++++++++
 tb/tb_rob_multiport.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer.
package rob_pkg;

  localparam int unsigned ITYPE_W_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 32;

  // Entry layout at the default widths. The buffer itself re-declares this
  // layout with its own ITYPE_W/DATA_W so that the widths stay overridable.
  typedef struct packed {
    logic                   busy;
    logic                   done;
    logic [ITYPE_W_DEF-1:0] itype;
    logic [4:0]             dest;
    logic [DATA_W_DEF-1:0]  value;
  } rob_entry_t;

  // Occupancy between two wrap-bit pointers that are ptr_w bits wide.
  function automatic int unsigned rob_ptr_dist(int unsigned head, int unsigned tail,
                                               int unsigned ptr_w);
    return (tail - head) & ((32'd1 << ptr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rob_cdb_match.sv
// Priority match of one ROB index against all CDB ports; lowest port wins.
module rob_cdb_match #(
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned IX_W    = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic [IX_W-1:0]           match_ix_in,
  input  logic [NUM_CDB-1:0]        cdb_valid_in,
  input  logic [NUM_CDB*IX_W-1:0]   cdb_ix_in,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value_in,
  output logic                      hit_out,
  output logic [DATA_W-1:0]         value_out
);

  // Scan ports upward and keep the first hit.
  always_comb begin
    logic found;
    found     = 1'b0;
    value_out = '0;
    for (int unsigned p = 0; p < NUM_CDB; p++) begin
      if (!found && cdb_valid_in[p] && (cdb_ix_in[p*IX_W +: IX_W] == match_ix_in)) begin
        found     = 1'b1;
        value_out = cdb_value_in[p*DATA_W +: DATA_W];
      end
    end
    hit_out = found;
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocate/commit, multi-port CDB writeback, flush.
// Optional macro ROB_BYPASS_EN: decode lookups also see same-cycle CDB results.
module rob_multiport
  import rob_pkg::*;
#(
  parameter  int unsigned SIZE    = 16,
  parameter  int unsigned NUM_CDB = 2,
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned ITYPE_W = ITYPE_W_DEF,
  localparam int unsigned IX_W    = $clog2(SIZE)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      issue_valid_in,
  input  logic [ITYPE_W-1:0]        issue_itype_in,
  input  logic [4:0]                issue_dest_in,
  input  logic [DATA_W-1:0]         issue_value_in,
  input  logic                      issue_done_in,
  output logic                      issue_ready_out,
  output logic [IX_W-1:0]           issue_ix_out,
  input  logic [IX_W-1:0]           decode_ix1_in,
  input  logic [IX_W-1:0]           decode_ix2_in,
  output logic [DATA_W-1:0]         decode_value1_out,
  output logic [DATA_W-1:0]         decode_value2_out,
  output logic                      decode_ready1_out,
  output logic                      decode_ready2_out,
  input  logic [NUM_CDB-1:0]        cdb_valid_in,
  input  logic [NUM_CDB*IX_W-1:0]   cdb_ix_in,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value_in,
  output logic                      commit_valid_out,
  input  logic                      commit_ready_in,
  output logic [ITYPE_W-1:0]        commit_itype_out,
  output logic [4:0]                commit_dest_out,
  output logic [DATA_W-1:0]         commit_value_out,
  output logic [IX_W-1:0]           commit_ix_out,
  input  logic                      flush_in,
  input  logic [IX_W-1:0]           flush_ix_in,
  output logic [IX_W:0]             count_out
);

  typedef struct packed {
    logic               busy;
    logic               done;
    logic [ITYPE_W-1:0] itype;
    logic [4:0]         dest;
    logic [DATA_W-1:0]  value;
  } entry_t;

  logic [IX_W:0]     head_q, head_d, tail_q, tail_d;
  entry_t            entries_q [SIZE];
  entry_t            entries_d [SIZE];

  logic [IX_W-1:0]   head_ix, tail_ix, keep_off;
  logic              full, do_issue, do_commit;
  logic [SIZE-1:0]   squash;
  logic [SIZE-1:0]   cdb_hit;
  logic [DATA_W-1:0] cdb_val [SIZE];

  assign head_ix  = head_q[IX_W-1:0];
  assign tail_ix  = tail_q[IX_W-1:0];
  assign full     = (head_ix == tail_ix) && (head_q[IX_W] != tail_q[IX_W]);
  assign keep_off = flush_ix_in - head_ix;

  assign issue_ready_out  = !full && !flush_in;
  assign issue_ix_out     = tail_ix;
  assign count_out        = (IX_W+1)'(rob_ptr_dist(32'(head_q), 32'(tail_q), IX_W + 1));
  assign commit_valid_out = entries_q[head_ix].busy && entries_q[head_ix].done;
  assign commit_itype_out = entries_q[head_ix].itype;
  assign commit_dest_out  = entries_q[head_ix].dest;
  assign commit_value_out = entries_q[head_ix].value;
  assign commit_ix_out    = head_ix;
  assign do_issue         = issue_valid_in && issue_ready_out;
  assign do_commit        = commit_valid_out && commit_ready_in;

  // One CDB matcher per entry.
  for (genvar g = 0; g < SIZE; g++) begin : g_match
    rob_cdb_match #(.NUM_CDB(NUM_CDB), .IX_W(IX_W), .DATA_W(DATA_W)) u_match (
      .match_ix_in (IX_W'(g)),
      .cdb_valid_in(cdb_valid_in),
      .cdb_ix_in   (cdb_ix_in),
      .cdb_value_in(cdb_value_in),
      .hit_out     (cdb_hit[g]),
      .value_out   (cdb_val[g])
    );
  end

  // Squash = entries whose distance from head lies beyond the surviving entry.
  always_comb begin
    squash = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      squash[i] = flush_in && ((IX_W'(i) - head_ix) > keep_off);
    end
  end

  // Next-state for pointers and entries: CDB, squash, commit, then issue.
  always_comb begin
    entries_d = entries_q;
    head_d    = do_commit ? head_q + (IX_W+1)'(1) : head_q;
    if (flush_in) begin
      // Tail is rebuilt from head so the wrap bit follows the surviving span.
      tail_d = head_q + (IX_W+1)'(keep_off) + (IX_W+1)'(1);
    end else if (do_issue) begin
      tail_d = tail_q + (IX_W+1)'(1);
    end else begin
      tail_d = tail_q;
    end
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (cdb_hit[i] && entries_q[i].busy && !squash[i]) begin
        entries_d[i].done  = 1'b1;
        entries_d[i].value = cdb_val[i];
      end
      if (squash[i]) begin
        entries_d[i].busy = 1'b0;
      end
    end
    if (do_commit) begin
      entries_d[head_ix].busy = 1'b0;
    end
    if (do_issue) begin
      entries_d[tail_ix].busy  = 1'b1;
      entries_d[tail_ix].done  = issue_done_in;
      entries_d[tail_ix].itype = issue_itype_in;
      entries_d[tail_ix].dest  = issue_dest_in;
      entries_d[tail_ix].value = issue_value_in;
    end
  end

  // State registers; reset discards every entry.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int unsigned i = 0; i < SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

`ifdef ROB_BYPASS_EN
  logic              byp1_hit, byp2_hit;
  logic [DATA_W-1:0] byp1_val, byp2_val;

  rob_cdb_match #(.NUM_CDB(NUM_CDB), .IX_W(IX_W), .DATA_W(DATA_W)) u_byp1 (
    .match_ix_in (decode_ix1_in),
    .cdb_valid_in(cdb_valid_in),
    .cdb_ix_in   (cdb_ix_in),
    .cdb_value_in(cdb_value_in),
    .hit_out     (byp1_hit),
    .value_out   (byp1_val)
  );

  rob_cdb_match #(.NUM_CDB(NUM_CDB), .IX_W(IX_W), .DATA_W(DATA_W)) u_byp2 (
    .match_ix_in (decode_ix2_in),
    .cdb_valid_in(cdb_valid_in),
    .cdb_ix_in   (cdb_ix_in),
    .cdb_value_in(cdb_value_in),
    .hit_out     (byp2_hit),
    .value_out   (byp2_val)
  );

  // Decode lookup with same-cycle CDB forwarding onto busy entries.
  always_comb begin
    decode_ready1_out = entries_q[decode_ix1_in].busy && (entries_q[decode_ix1_in].done || byp1_hit);
    decode_ready2_out = entries_q[decode_ix2_in].busy && (entries_q[decode_ix2_in].done || byp2_hit);
    decode_value1_out = (entries_q[decode_ix1_in].busy && byp1_hit) ? byp1_val
                                                                    : entries_q[decode_ix1_in].value;
    decode_value2_out = (entries_q[decode_ix2_in].busy && byp2_hit) ? byp2_val
                                                                    : entries_q[decode_ix2_in].value;
  end
`else
  // Decode lookup from registered entries only.
  always_comb begin
    decode_ready1_out = entries_q[decode_ix1_in].busy && entries_q[decode_ix1_in].done;
    decode_ready2_out = entries_q[decode_ix2_in].busy && entries_q[decode_ix2_in].done;
    decode_value1_out = entries_q[decode_ix1_in].value;
    decode_value2_out = entries_q[decode_ix2_in].value;
  end
`endif

  a_flush_ix_busy: assert property (@(posedge clk_in) disable iff (rst_in)
    flush_in |-> entries_q[flush_ix_in].busy);

endmodule

// File: tb/tb_rob_multiport.sv
// Scoreboard bench for rob_multiport at default parameters.
module tb_rob_multiport;
  import rob_pkg::*;

  localparam int unsigned SIZE = 16;
  localparam int unsigned NCDB = 2;
  localparam int unsigned DW   = 32;
  localparam int unsigned ITW  = 4;
  localparam int unsigned IXW  = 4;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               issue_valid_in;
  logic [ITW-1:0]     issue_itype_in;
  logic [4:0]         issue_dest_in;
  logic [DW-1:0]      issue_value_in;
  logic               issue_done_in;
  logic               issue_ready_out;
  logic [IXW-1:0]     issue_ix_out;
  logic [IXW-1:0]     decode_ix1_in, decode_ix2_in;
  logic [DW-1:0]      decode_value1_out, decode_value2_out;
  logic               decode_ready1_out, decode_ready2_out;
  logic [NCDB-1:0]    cdb_valid_in;
  logic [NCDB*IXW-1:0] cdb_ix_in;
  logic [NCDB*DW-1:0] cdb_value_in;
  logic               commit_valid_out;
  logic               commit_ready_in;
  logic [ITW-1:0]     commit_itype_out;
  logic [4:0]         commit_dest_out;
  logic [DW-1:0]      commit_value_out;
  logic [IXW-1:0]     commit_ix_out;
  logic               flush_in;
  logic [IXW-1:0]     flush_ix_in;
  logic [IXW:0]       count_out;

  int unsigned        n_checks = 0;
  int unsigned        n_errors = 0;
  rob_entry_t         exp_q[$];
  logic [IXW-1:0]     exp_ix_q[$];

  always #5 clk_in = ~clk_in;

  rob_multiport #(.SIZE(SIZE), .NUM_CDB(NCDB), .DATA_W(DW), .ITYPE_W(ITW)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .issue_valid_in(issue_valid_in), .issue_itype_in(issue_itype_in),
    .issue_dest_in(issue_dest_in), .issue_value_in(issue_value_in),
    .issue_done_in(issue_done_in), .issue_ready_out(issue_ready_out),
    .issue_ix_out(issue_ix_out),
    .decode_ix1_in(decode_ix1_in), .decode_ix2_in(decode_ix2_in),
    .decode_value1_out(decode_value1_out), .decode_value2_out(decode_value2_out),
    .decode_ready1_out(decode_ready1_out), .decode_ready2_out(decode_ready2_out),
    .cdb_valid_in(cdb_valid_in), .cdb_ix_in(cdb_ix_in), .cdb_value_in(cdb_value_in),
    .commit_valid_out(commit_valid_out), .commit_ready_in(commit_ready_in),
    .commit_itype_out(commit_itype_out), .commit_dest_out(commit_dest_out),
    .commit_value_out(commit_value_out), .commit_ix_out(commit_ix_out),
    .flush_in(flush_in), .flush_ix_in(flush_ix_in), .count_out(count_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned it, input int unsigned d, input logic [DW-1:0] v,
                      input int unsigned ix);
    rob_entry_t e;
    e.busy  = 1'b1;
    e.done  = 1'b1;
    e.itype = ITW'(it);
    e.dest  = 5'(d);
    e.value = v;
    exp_q.push_back(e);
    exp_ix_q.push_back(IXW'(ix));
  endtask

  task automatic drive_issue(input int unsigned it, input int unsigned d,
                             input logic [DW-1:0] v, input logic done);
    issue_valid_in = 1'b1;
    issue_itype_in = ITW'(it);
    issue_dest_in  = 5'(d);
    issue_value_in = v;
    issue_done_in  = done;
  endtask

  task automatic drive_cdb(input logic [1:0] vld, input int unsigned ix0, input logic [DW-1:0] v0,
                           input int unsigned ix1, input logic [DW-1:0] v1);
    cdb_valid_in = vld;
    cdb_ix_in    = {IXW'(ix1), IXW'(ix0)};
    cdb_value_in = {v1, v0};
  endtask

  // Settle, score any commit handshake, then advance one clock.
  task automatic tick();
    rob_entry_t     e;
    logic [IXW-1:0] ix;
    #1;
    if (commit_valid_out && commit_ready_in) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        ix = exp_ix_q.pop_front();
        check("commit_ix", 64'(commit_ix_out), 64'(ix));
        check("commit_itype", 64'(commit_itype_out), 64'(e.itype));
        check("commit_dest", 64'(commit_dest_out), 64'(e.dest));
        check("commit_value", 64'(commit_value_out), 64'(e.value));
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    issue_valid_in = 1'b0; issue_itype_in = '0; issue_dest_in = '0;
    issue_value_in = '0; issue_done_in = 1'b0;
    decode_ix1_in = '0; decode_ix2_in = '0;
    cdb_valid_in = '0; cdb_ix_in = '0; cdb_value_in = '0;
    commit_ready_in = 1'b0; flush_in = 1'b0; flush_ix_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_ready", 64'(issue_ready_out), 64'd1);
    check("rst_count", 64'(count_out), 64'd0);
    check("rst_commit_valid", 64'(commit_valid_out), 64'd0);
    check("rst_issue_ix", 64'(issue_ix_out), 64'd0);
    check("rst_commit_value", 64'(commit_value_out), 64'd0);
    check("rst_dec_ready", 64'(decode_ready1_out), 64'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Fill to full with 17 issue attempts; the last is dropped.
    for (int unsigned i = 0; i < 17; i++) begin
      drive_issue(i, i, DW'(i), 1'b1);
      #1;
      if (i < 16) begin
        check("fill_ix", 64'(issue_ix_out), 64'(i));
        check("fill_ready", 64'(issue_ready_out), 64'd1);
        push(i, i, DW'(i), i);
      end else begin
        check("full_ready", 64'(issue_ready_out), 64'd0);
      end
      tick();
    end
    issue_valid_in = 1'b0;
    check("full_count", 64'(count_out), 64'd16);
    commit_ready_in = 1'b1;
    for (int unsigned i = 0; i < 16; i++) tick();
    commit_ready_in = 1'b0;
    check("drain_count", 64'(count_out), 64'd0);

    // Four pending entries at ix 0..3; two ports write in one cycle.
    push(1, 10, 32'h10, 0); push(1, 11, 32'h11, 1);
    push(1, 12, 32'h22, 2); push(1, 13, 32'hAA, 3);
    for (int unsigned k = 0; k < 4; k++) begin
      drive_issue(1, 10 + k, '0, 1'b0);
      #1;
      check("p4_ix", 64'(issue_ix_out), 64'(k));
      tick();
    end
    issue_valid_in = 1'b0;
    drive_cdb(2'b11, 0, 32'h10, 2, 32'h22);
    decode_ix1_in = 4'd2;
    #1;
    check("cdb_pre_commit_valid", 64'(commit_valid_out), 64'd0);
`ifdef ROB_BYPASS_EN
    check("byp_ready", 64'(decode_ready1_out), 64'd1);
    check("byp_value", 64'(decode_value1_out), 64'h22);
`else
    check("nobyp_ready", 64'(decode_ready1_out), 64'd0);
`endif
    tick();
    cdb_valid_in = '0;
    #1;
    check("cdb_commit_valid", 64'(commit_valid_out), 64'd1);
    check("cdb_commit_value", 64'(commit_value_out), 64'h10);
    check("dec_next_ready", 64'(decode_ready1_out), 64'd1);
    check("dec_next_value", 64'(decode_value1_out), 64'h22);
    commit_ready_in = 1'b1;
    tick();
    check("block_valid", 64'(commit_valid_out), 64'd0);
    check("block_ix", 64'(commit_ix_out), 64'd1);

    // Both ports to ix 3: port 0 wins.
    drive_cdb(2'b11, 3, 32'hAA, 3, 32'hBB);
    decode_ix1_in = 4'd3;
    tick();
    cdb_valid_in = '0;
    check("prio_ready", 64'(decode_ready1_out), 64'd1);
    check("prio_value", 64'(decode_value1_out), 64'hAA);
    drive_cdb(2'b01, 1, 32'h11, 0, '0);
    tick();
    cdb_valid_in = '0;
    for (int unsigned k = 0; k < 3; k++) tick();
    check("p4_drain_count", 64'(count_out), 64'd0);

    // 20 back-to-back issue/commit pairs starting at ix 4.
    for (int unsigned k = 0; k < 20; k++) begin
      drive_issue(k % 16, k, 32'h100 + k, 1'b1);
      push(k % 16, k, 32'h100 + k, (4 + k) % 16);
      tick();
    end
    issue_valid_in = 1'b0;
    tick();
    check("wrap_count", 64'(count_out), 64'd0);
    commit_ready_in = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      drive_issue(k, k + 3, 32'h200 + k, 1'b1);
      push(k, k + 3, 32'h200 + k, (8 + k) % 16);
      tick();
    end
    check("wrap_full_count", 64'(count_out), 64'd16);
    check("wrap_full_ready", 64'(issue_ready_out), 64'd0);
    drive_issue(0, 0, 32'hDEAD, 1'b1);
    commit_ready_in = 1'b1;
    #1;
    check("full_issue_commit_ready", 64'(issue_ready_out), 64'd0);
    tick();
    issue_valid_in = 1'b0;
    check("full_issue_commit_count", 64'(count_out), 64'd15);
    for (int unsigned k = 0; k < 15; k++) tick();
    check("wrap_drain_count", 64'(count_out), 64'd0);
    commit_ready_in = 1'b0;

    // Flush: 8 entries at ix 8..15, keep through ix 11.
    for (int unsigned k = 0; k < 8; k++) begin
      drive_issue(2, 20 + k, 32'h300 + k, 1'b0);
      if (k < 4) push(2, 20 + k, 32'h400 + k, 8 + k);
      tick();
    end
    drive_issue(3, 3, 32'hBAD, 1'b1);
    flush_in = 1'b1;
    flush_ix_in = 4'd11;
    drive_cdb(2'b01, 14, 32'hEE, 0, '0);
    #1;
    check("flush_ready", 64'(issue_ready_out), 64'd0);
    tick();
    flush_in = 1'b0;
    issue_valid_in = 1'b0;
    cdb_valid_in = '0;
    decode_ix1_in = 4'd14;
    #1;
    check("flush_count", 64'(count_out), 64'd4);
    check("flush_issue_ix", 64'(issue_ix_out), 64'd12);
    check("flush_sq_ready", 64'(decode_ready1_out), 64'd0);
    drive_cdb(2'b01, 13, 32'h55, 0, '0);
    decode_ix2_in = 4'd13;
    tick();
    cdb_valid_in = '0;
    check("flush_late_cdb", 64'(decode_ready2_out), 64'd0);
    drive_issue(7, 7, 32'h77, 1'b1);
    #1;
    check("post_flush_ix", 64'(issue_ix_out), 64'd12);
    push(7, 7, 32'h77, 12);
    tick();
    issue_valid_in = 1'b0;
    decode_ix1_in = 4'd12;
    #1;
    check("post_flush_dec_ready", 64'(decode_ready1_out), 64'd1);
    check("post_flush_dec_value", 64'(decode_value1_out), 64'h77);
    drive_cdb(2'b11, 8, 32'h400, 9, 32'h401);
    tick();
    drive_cdb(2'b11, 10, 32'h402, 11, 32'h403);
    tick();
    cdb_valid_in = '0;
    commit_ready_in = 1'b1;
    for (int unsigned k = 0; k < 5; k++) tick();
    check("flush_drain_count", 64'(count_out), 64'd0);
    commit_ready_in = 1'b0;

    // Asynchronous reset while entries are occupied.
    for (int unsigned k = 0; k < 2; k++) begin
      drive_issue(1, 1, 32'h9, 1'b1);
      tick();
    end
    issue_valid_in = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_count", 64'(count_out), 64'd0);
    check("arst_commit_valid", 64'(commit_valid_out), 64'd0);
    check("arst_ready", 64'(issue_ready_out), 64'd1);
    check("arst_issue_ix", 64'(issue_ix_out), 64'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
